// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq
// Brief    : Sequential ALU with valid/ready handshake, persistent NZCV flags
//            and an optional iterative shift-add multiplier.
// Revision : 1.0 - initial release
// ============================================================================
module alu_seq #(
  parameter int WIDTH  = 16,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             n_flag,
  output logic             z_flag,
  output logic             c_flag,
  output logic             v_flag
);

  localparam int SH_W = $clog2(WIDTH);
  localparam int MSB  = WIDTH - 1;

  localparam logic [3:0] C_OP_ADD = 4'd0;
  localparam logic [3:0] C_OP_SUB = 4'd1;
  localparam logic [3:0] C_OP_ADC = 4'd2;
  localparam logic [3:0] C_OP_SBC = 4'd3;
  localparam logic [3:0] C_OP_AND = 4'd4;
  localparam logic [3:0] C_OP_OR  = 4'd5;
  localparam logic [3:0] C_OP_XOR = 4'd6;
  localparam logic [3:0] C_OP_NOT = 4'd7;
  localparam logic [3:0] C_OP_SHL = 4'd8;
  localparam logic [3:0] C_OP_SHR = 4'd9;
  localparam logic [3:0] C_OP_SAR = 4'd10;
  localparam logic [3:0] C_OP_MUL = 4'd11;
  localparam logic [3:0] C_OP_CMP = 4'd12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t r_state, w_state_nxt;

  logic [WIDTH-1:0]   r_result;
  logic               r_n, r_z, r_c, r_v;
  logic [2*WIDTH-1:0] r_mcand, r_acc, w_acc_nxt;
  logic [WIDTH-1:0]   r_mplier;
  logic [SH_W-1:0]    r_cnt;

  logic             w_fire, w_is_mul, w_mul_last;
  logic [WIDTH-1:0] w_addend, w_res;
  logic             w_cin, w_c, w_v, w_write;
  logic [WIDTH:0]   w_sum, w_shl, w_shr, w_sar;
  logic [SH_W-1:0]  w_sh;

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign result    = r_result;
  assign n_flag    = r_n;
  assign z_flag    = r_z;
  assign c_flag    = r_c;
  assign v_flag    = r_v;

  assign w_fire     = in_valid & in_ready;
  assign w_is_mul   = MUL_EN && (op == C_OP_MUL);
  assign w_acc_nxt  = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_mul_last = (r_cnt == SH_W'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_fire) w_state_nxt = w_is_mul ? ST_MUL : ST_DONE;
      ST_MUL:  if (w_mul_last) w_state_nxt = ST_DONE;
      ST_DONE: if (out_ready) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Single adder serves ADD/SUB/ADC/SBC/CMP; subtraction is A + ~B + cin.
  always_comb begin
    w_addend = b;
    w_cin    = 1'b0;
    case (op)
      C_OP_SUB, C_OP_CMP: begin w_addend = ~b; w_cin = 1'b1; end
      C_OP_ADC:           w_cin = r_c;
      C_OP_SBC:           begin w_addend = ~b; w_cin = r_c; end
      default:            ;
    endcase
    w_sum = {1'b0, a} + {1'b0, w_addend} + {{WIDTH{1'b0}}, w_cin};
    w_sh  = b[SH_W-1:0];
    // Extra bit on each shift captures the last bit shifted out (0 for amount 0).
    w_shl = {1'b0, a} << w_sh;
    w_shr = {a, 1'b0} >> w_sh;
    w_sar = $signed({a, 1'b0}) >>> w_sh;

    w_res   = '0;
    w_c     = 1'b0;
    w_v     = 1'b0;
    w_write = 1'b1;
    case (op)
      C_OP_ADD, C_OP_SUB, C_OP_ADC, C_OP_SBC, C_OP_CMP: begin
        w_res   = w_sum[WIDTH-1:0];
        w_c     = w_sum[WIDTH];
        w_v     = (a[MSB] == w_addend[MSB]) && (w_sum[MSB] != a[MSB]);
        w_write = (op != C_OP_CMP);
      end
      C_OP_AND: w_res = a & b;
      C_OP_OR:  w_res = a | b;
      C_OP_XOR: w_res = a ^ b;
      C_OP_NOT: w_res = ~a;
      C_OP_SHL: begin w_res = w_shl[WIDTH-1:0]; w_c = w_shl[WIDTH]; end
      C_OP_SHR: begin w_res = w_shr[WIDTH:1];   w_c = w_shr[0];     end
      C_OP_SAR: begin w_res = w_sar[WIDTH:1];   w_c = w_sar[0];     end
      default: begin
        w_c = r_c;
        w_v = r_v;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_result <= '0;
      r_n      <= 1'b0;
      r_z      <= 1'b0;
      r_c      <= 1'b0;
      r_v      <= 1'b0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_fire) begin
          if (w_is_mul) begin
            r_mcand  <= {{WIDTH{1'b0}}, a};
            r_mplier <= b;
            r_acc    <= '0;
            r_cnt    <= '0;
          end else begin
            if (w_write) r_result <= w_res;
            r_n <= w_res[MSB];
            r_z <= (w_res == '0);
            r_c <= w_c;
            r_v <= w_v;
          end
        end
        ST_MUL: begin
          r_acc    <= w_acc_nxt;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 1'b1;
          if (w_mul_last) begin
            r_result <= w_acc_nxt[WIDTH-1:0];
            r_n      <= w_acc_nxt[MSB];
            r_z      <= (w_acc_nxt[WIDTH-1:0] == '0);
            r_c      <= (w_acc_nxt[2*WIDTH-1:WIDTH] != '0);
            r_v      <= (w_acc_nxt[2*WIDTH-1:WIDTH] != '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_seq
// Brief    : Self-checking bench for alu_seq with an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_seq;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_ready, out_valid, out_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] a, b, result;
  logic             n_flag, z_flag, c_flag, v_flag;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int m_res, m_n, m_z, m_c, m_v;

  alu_seq #(.WIDTH(WIDTH), .MUL_EN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .n_flag(n_flag), .z_flag(z_flag), .c_flag(c_flag), .v_flag(v_flag)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sgn(input int x);
    return (x >= 32768) ? x - 65536 : x;
  endfunction

  // Computes expected outcome from plain integer arithmetic.
  function automatic void model(input int o, input int x, input int y);
    int r, s, sr, n;
    longint p;
    int c, v;
    bit wr;
    r = 0; c = 0; v = 0; wr = 1'b1;
    n = y & 15;
    case (o)
      0:  begin s = x + y;               sr = sgn(x) + sgn(y); end
      1, 12: begin s = x + (65535 - y) + 1; sr = sgn(x) - sgn(y); end
      2:  begin s = x + y + m_c;         sr = sgn(x) + sgn(y) + m_c; end
      3:  begin s = x + (65535 - y) + m_c; sr = sgn(x) - sgn(y) - 1 + m_c; end
      default: begin s = 0; sr = 0; end
    endcase
    case (o)
      0, 1, 2, 3, 12: begin
        r = s & 65535;
        c = (s >= 65536) ? 1 : 0;
        v = (sr > 32767 || sr < -32768) ? 1 : 0;
        wr = (o != 12);
      end
      4:  r = x & y;
      5:  r = x | y;
      6:  r = x ^ y;
      7:  r = (~x) & 65535;
      8:  begin r = (x << n) & 65535; c = (n == 0) ? 0 : (x >> (16 - n)) & 1; end
      9:  begin r = x >> n;           c = (n == 0) ? 0 : (x >> (n - 1)) & 1; end
      10: begin r = (sgn(x) >>> n) & 65535; c = (n == 0) ? 0 : (sgn(x) >>> (n - 1)) & 1; end
      11: begin
        p = longint'(x) * longint'(y);
        r = int'(p & 64'hFFFF);
        c = ((p >> 16) != 0) ? 1 : 0;
        v = c;
      end
      default: begin c = m_c; v = m_v; end
    endcase
    if (wr) m_res = r;
    m_n = (r >> 15) & 1;
    m_z = (r == 0) ? 1 : 0;
    m_c = c;
    m_v = v;
  endfunction

  // Issue one op, check latency/result/flags, optionally stall the consumer.
  task automatic do_op(input int o, input int x, input int y, input int hold);
    int lat;
    logic [WIDTH-1:0] r0;
    logic [3:0] f0;
    @(negedge clk);
    check($sformatf("ready_before_op%0d", o), in_ready, 1'b1);
    op = 4'(o); a = 16'(x); b = 16'(y); in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    model(o, x, y);
    lat = 0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
    end
    check($sformatf("latency_op%0d", o), lat, (o == 11) ? 17 : 1);
    check($sformatf("result_op%0d_%0h_%0h", o, x, y), result, 32'(m_res));
    check($sformatf("nzcv_op%0d_%0h_%0h", o, x, y), {n_flag, z_flag, c_flag, v_flag},
          {m_n[0], m_z[0], m_c[0], m_v[0]});
    check("ready_low_in_done", in_ready, 1'b0);
    r0 = result;
    f0 = {n_flag, z_flag, c_flag, v_flag};
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; op = 4'd0; a = 16'h0001; b = 16'h0001;
      @(negedge clk);
      check("hold_valid", out_valid, 1'b1);
      check("hold_ready", in_ready, 1'b0);
      check("hold_result", result, r0);
      check("hold_flags", {n_flag, z_flag, c_flag, v_flag}, f0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check("valid_drop", out_valid, 1'b0);
    check("ready_back", in_ready, 1'b1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
    m_res = 0; m_n = 0; m_z = 0; m_c = 0; m_v = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_result", result, 16'h0000);
    check("rst_flags", {n_flag, z_flag, c_flag, v_flag}, 4'b0000);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    @(negedge clk) rst = 1'b0;

    // Directed steps
    do_op(0, 'h1234, 'h4321, 0);
    check("add_literal", result, 16'h5555);
    do_op(1, 'h1234, 'h4321, 0);
    check("sub_literal", {result, n_flag, z_flag, c_flag, v_flag}, {16'hCF13, 4'b1000});
    do_op(0, 'h7FFF, 'h0001, 0);
    do_op(1, 'h8000, 'h0001, 0);
    do_op(0, 'hFFFF, 'h0001, 0);
    do_op(2, 'h0000, 'h0000, 0);
    check("adc_literal", {result, c_flag}, {16'h0001, 1'b0});
    do_op(12, 5, 5, 0);
    check("cmp_keeps_result", {result, z_flag, c_flag}, {16'h0001, 1'b1, 1'b1});
    do_op(9, 'h8001, 1, 0);
    do_op(10, 'h8000, 4, 0);
    do_op(8, 'h0001, 0, 0);
    do_op(11, 'h00FF, 'h0003, 0);
    check("mul_literal", result, 16'h02FD);
    do_op(11, 'h0100, 'h0100, 0);
    do_op(3, 'h1000, 'h0FFF, 0);
    do_op(14, 'h1234, 'h5678, 0);
    do_op(6, 'hA5A5, 'hFFFF, 5);

    // Reset in the middle of a multiply
    @(negedge clk);
    op = 4'd11; a = 16'hABCD; b = 16'h1234; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midmul_rst_result", result, 16'h0000);
    check("midmul_rst_flags", {n_flag, z_flag, c_flag, v_flag}, 4'b0000);
    check("midmul_rst_valid", out_valid, 1'b0);
    check("midmul_rst_ready", in_ready, 1'b1);
    m_res = 0; m_n = 0; m_z = 0; m_c = 0; m_v = 0;
    @(negedge clk) rst = 1'b0;
    do_op(0, 'h0102, 'h0304, 0);

    // Randomized ops against the model
    for (int k = 0; k < 40; k++) begin
      do_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 65535)),
            int'($urandom_range(0, 65535)), int'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised, clocked successor to the combinational 16-bit add/sub ALU.
- Accepts one operation at a time over a valid/ready handshake.
- Executes arithmetic, logic, shift and a multi-cycle shift-add multiply.
- Holds a registered result plus persistent N/Z/C/V flags, so multi-word ADC/SBC chains work.
- Sits between the datapath operand registers and the writeback stage.

Parameters:
WIDTH, 16, operand/result width in bits (>=4, power of 2)
MUL_EN, 1, 1 = MUL opcode implemented; 0 = MUL treated as reserved
(localparam SH_W = clog2(WIDTH), the shift-amount width)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  operand/op presented
in_ready  out  1  block can accept an operation (high only in IDLE)
op  in  4  opcode
a  in  WIDTH  operand A
b  in  WIDTH  operand B (shift amount = b[SH_W-1:0])
out_valid  out  1  result/flags valid, held until accepted
out_ready  in  1  consumer accepts result
result  out  WIDTH  registered result
n_flag  out  1  negative (result MSB)
z_flag  out  1  zero
c_flag  out  1  carry / no-borrow / shift-out
v_flag  out  1  signed overflow

Behaviour:
- Reset (async, any state, including mid-MUL): FSM->IDLE; result=0; n,z,c,v=0; out_valid=0; in_ready=1; multiplier registers cleared.
- FSM states:
  - IDLE: in_ready=1; on in_valid&in_ready, latch a, b, op and current c_flag. Non-MUL -> DONE next edge with result/flags loaded. MUL -> MUL.
  - MUL: WIDTH iterations, one per cycle, of unsigned shift-add into a 2*WIDTH accumulator; after the last iteration load result/flags -> DONE.
  - DONE: out_valid=1, in_ready=0; outputs stable while out_ready=0; on out_ready -> IDLE, out_valid=0 next edge.
- Latency, acceptance edge T to out_valid: non-MUL at T+1; MUL at T+WIDTH+1. Throughput max one op per 2 cycles; no overlap.
- Opcodes, flags updated only when result loads:
  - 0 ADD: A+B. C = carry-out. V = (A[msb]==B[msb]) & (R[msb]!=A[msb]).
  - 1 SUB: A+~B+1. C = carry-out (1 = no borrow). V = (A[msb]!=B[msb]) & (R[msb]!=A[msb]).
  - 2 ADC: A+B+Cin. 3 SBC: A+~B+Cin. Cin = c_flag latched at accept. C/V as ADD/SUB.
  - 4 AND, 5 OR, 6 XOR, 7 NOT A: C=0, V=0.
  - 8 SHL, 9 SHR (logical), 10 SAR (arithmetic), by b[SH_W-1:0].
    - C = last bit shifted out; C=0 when amount=0. V=0.
  - 11 MUL: result = low WIDTH bits of unsigned A*B; C=V=(high WIDTH bits != 0).
  - 12 CMP: flags as SUB; result register unchanged.
  - 13-15 reserved (and 11 when MUL_EN=0): result=0, N=0, Z=1, C and V unchanged.
- N = result MSB, Z = (result==0), computed on the value loaded. For CMP, computed on the A-B difference.
- All arithmetic modulo 2^WIDTH; carry from a WIDTH+1-bit sum.
- Inputs ignored whenever in_ready=0; in_valid held high during DONE is accepted only after return to IDLE.
- in_valid and out_ready both high in DONE: the DONE->IDLE transition only; new op accepted the following cycle.

Test Plan:
- WIDTH=16, ADD 0x1234+0x4321 -> result 0x5555, NZCV=0000, out_valid at T+1. SUB same operands -> 0xCF13, NZCV=1000.
- ADD 0x7FFF+0x0001 -> 0x8000, NZCV=1001. SUB 0x8000-0x0001 -> 0x7FFF, NZCV=0011.
- Carry chain: ADD 0xFFFF+0x0001 -> 0x0000, Z=1, C=1. Then ADC 0x0000+0x0000 -> 0x0001, C=0. Then CMP 5,5 -> Z=1, C=1, result stays 0x0001.
- Shifts: SHR 0x8001 by 1 -> 0x4000, C=1. SAR 0x8000 by 4 -> 0xF800, N=1. SHL 0x0001 by 0 -> 0x0001, C=0.
- MUL 0x00FF*0x0003 -> 0x02FD, C=V=0, out_valid exactly at T+17. MUL 0x0100*0x0100 -> 0x0000, Z=1, C=V=1.
- Backpressure/reset: hold out_ready=0 for 5 cycles -> result, flags, out_valid stable and in_ready=0. Assert rst at MUL iteration 7 -> all outputs 0, in_ready=1 immediately; a subsequent ADD completes correctly.
